// File: rtl/mp_add_seq.sv
// Word-serial multi-precision add/subtract sequencer driving an external single-cycle adder.
// Optional subtraction support is enabled by defining MPADD_SUB_EN.
module mp_add_seq #(
  parameter int unsigned WORD_W    = 48,
  parameter int unsigned NUM_WORDS = 22,
  parameter int unsigned CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              carry_init,
  input  logic              sub,
  output logic              busy,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done,
  output logic              carry_final,
  output logic [WORD_W-1:0] add_a,
  output logic [WORD_W-1:0] add_b,
  output logic              add_cin,
  input  logic [WORD_W-1:0] add_sum,
  input  logic              add_cout
);

  localparam logic [CNT_W-1:0] NumWordsC = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LastIdx   = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WORD_W-1:0]  out_word_q, out_word_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               carry_final_q, carry_final_d;
  logic               sub_q;
  logic               sub_start;
  logic               accept;
  logic               out_hs;

`ifdef MPADD_SUB_EN
  logic sub_d;

  always_comb begin
    sub_d = sub_q;
    if (state_q == StIdle && start) sub_d = sub;
  end

  always_ff @(posedge clk) begin
    if (rst) sub_q <= 1'b0;
    else     sub_q <= sub_d;
  end

  assign sub_start = sub;
  assign add_b     = sub_q ? ~in_b : in_b;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_q      = 1'b0;
  assign sub_start  = 1'b0;
  assign add_b      = in_b;
`endif

  assign add_a   = in_a;
  assign add_cin = carry_q;

  assign in_ready = (state_q == StRun) && (cnt_q < NumWordsC) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign out_word    = out_word_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign carry_final = carry_final_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    out_word_d    = out_word_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    carry_final_d = carry_final_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          cnt_d      = '0;
          carry_d    = carry_init ^ sub_start;
          out_last_d = 1'b0;
        end
      end
      StRun: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          // carry_q is already final here: the last word was accepted at least a cycle earlier
          if (out_last_q) begin
            state_d       = StDone;
            carry_final_d = carry_q ^ sub_q;
          end
        end
        if (accept) begin
          out_word_d  = add_sum;
          carry_d     = add_cout;
          cnt_d       = cnt_q + CNT_W'(1);
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == LastIdx);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      out_word_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      carry_final_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      out_word_q    <= out_word_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      carry_final_q <= carry_final_d;
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: table vectors, backpressure/reset sequences and random ops
// compared against whole-operand arithmetic.
module tb_mp_add_seq;
  localparam int unsigned W   = 48;
  localparam int unsigned NW  = 4;
  localparam int unsigned CW  = 3;
  localparam int          TOT = W * NW;
`ifdef MPADD_SUB_EN
  localparam bit SubOn = 1'b1;
`else
  localparam bit SubOn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, carry_init, sub, busy;
  logic [W-1:0] in_a, in_b, out_word, add_a, add_b, add_sum;
  logic         in_valid, in_ready, out_valid, out_ready, out_last, done, carry_final;
  logic         add_cin, add_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External single-cycle adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  mp_add_seq #(.WORD_W(W), .NUM_WORDS(NW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .carry_init(carry_init), .sub(sub), .busy(busy),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .done(done), .carry_final(carry_final),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  typedef struct {
    logic [TOT-1:0] a;
    logic [TOT-1:0] b;
    logic           cin;
    logic           s;
    int             mode;
    logic [TOT-1:0] exp_r;
    logic           exp_c;
    string          name;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                                input logic cin, input logic s,
                                output logic [TOT-1:0] r, output logic c);
    logic [TOT:0] full;
    if (s && SubOn) begin
      full = {1'b0, a} - {1'b0, b} - {{TOT{1'b0}}, cin};
      r    = full[TOT-1:0];
      c    = ({1'b0, a} < ({1'b0, b} + {{TOT{1'b0}}, cin}));
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{TOT{1'b0}}, cin};
      r    = full[TOT-1:0];
      c    = full[TOT];
    end
  endfunction

  // mode 0: full throughput, 1: random valid/ready, 2: out_ready low 3 cycles on word 1
  task automatic run_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic cin,
                        input logic s, input int mode, input string name,
                        input logic [TOT-1:0] exp_r, input logic exp_c);
    logic [TOT-1:0] got;
    logic [W-1:0]   held;
    int ni, no, cyc, stall, first_out, last_out;
    bit done_seen;
    got = '0; held = '0; ni = 0; no = 0; cyc = 0; stall = 0;
    first_out = -1; last_out = -1; done_seen = 0;
    start = 1'b1; carry_init = cin; sub = s;
    @(posedge clk); #1;
    start = 1'b0; carry_init = ~cin; sub = ~s;
    chk({name, " busy"}, 256'(busy), 256'(1));
    while (!done_seen && cyc < 200) begin
      in_valid = (ni < NW) && (mode != 1 || $urandom_range(3) != 0);
      in_a     = (ni < NW) ? a[ni*W +: W] : W'({$urandom, $urandom});
      in_b     = (ni < NW) ? b[ni*W +: W] : W'({$urandom, $urandom});
      if (mode == 1) out_ready = ($urandom_range(2) != 0);
      else if (mode == 2 && out_valid && no == 1 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else out_ready = 1'b1;
      @(negedge clk);
      if (mode == 2 && !out_ready && out_valid) begin
        chk({name, " stall in_ready"}, 256'(in_ready), 256'(0));
        if (stall == 1) held = out_word;
        else chk({name, " held word"}, 256'(out_word), 256'(held));
      end
      if (done) begin
        done_seen = 1;
        chk({name, " carry_final"}, 256'(carry_final), 256'(exp_c));
      end
      if (out_valid && out_ready) begin
        if (no < NW) begin
          got[no*W +: W] = out_word;
          chk({name, " out_last"}, 256'(out_last), 256'(no == NW - 1));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        no++;
      end
      if (in_valid && in_ready) ni++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk({name, " done seen"}, 256'(done_seen), 256'(1));
    chk({name, " word count"}, 256'(no), 256'(NW));
    chk({name, " result"}, 256'(got), 256'(exp_r));
    if (mode == 0) chk({name, " throughput"}, 256'(last_out - first_out), 256'(NW - 1));
    if (mode == 2) chk({name, " stall cycles"}, 256'(stall), 256'(3));
    @(negedge clk);
    chk({name, " done pulse"}, 256'(done), 256'(0));
    chk({name, " idle busy"}, 256'(busy), 256'(0));
    chk({name, " carry held"}, 256'(carry_final), 256'(exp_c));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " busy"}, 256'(busy), 256'(0));
    chk({name, " in_ready"}, 256'(in_ready), 256'(0));
    chk({name, " out_valid"}, 256'(out_valid), 256'(0));
    chk({name, " out_last"}, 256'(out_last), 256'(0));
    chk({name, " done"}, 256'(done), 256'(0));
    chk({name, " carry_final"}, 256'(carry_final), 256'(0));
    chk({name, " out_word"}, 256'(out_word), 256'(0));
  endtask

  initial begin
    vec_t           vecs[$];
    vec_t           v;
    logic [TOT-1:0] a, b, er;
    logic           ec, cin, s;
    logic [TOT-1:0] ones;

    ones = '1;
    v = '{a: 192'hFFFF_FFFF_FFFF, b: 192'h1, cin: 0, s: 0, mode: 0,
          exp_r: 192'h1 << 48, exp_c: 0, name: "carry chain"};
    vecs.push_back(v);
    v = '{a: ones, b: 192'h1, cin: 0, s: 0, mode: 0, exp_r: '0, exp_c: 1, name: "overflow"};
    vecs.push_back(v);
    v = '{a: '0, b: '0, cin: 1, s: 0, mode: 1, exp_r: 192'h1, exp_c: 0, name: "cin only"};
    vecs.push_back(v);
    v = '{a: ones, b: '0, cin: 1, s: 0, mode: 1, exp_r: '0, exp_c: 1, name: "cin ripple"};
    vecs.push_back(v);
`ifdef MPADD_SUB_EN
    v = '{a: 192'h5, b: 192'h7, cin: 0, s: 1, mode: 0, exp_r: ones - 192'h1, exp_c: 1,
          name: "sub borrow"};
    vecs.push_back(v);
    v = '{a: 192'h9, b: 192'h7, cin: 0, s: 1, mode: 1, exp_r: 192'h2, exp_c: 0,
          name: "sub no borrow"};
    vecs.push_back(v);
`endif

    rst = 1'b1; start = 1'b0; carry_init = 1'b0; sub = 1'b0;
    in_a = '0; in_b = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;

    foreach (vecs[i]) begin
      model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, er, ec);
      chk({vecs[i].name, " model"}, 256'(er), 256'(vecs[i].exp_r));
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].mode, vecs[i].name,
             vecs[i].exp_r, vecs[i].exp_c);
    end

    // Backpressure on word 1
    a = {W'(48'h1234_5678_9ABC), W'(48'hFFFF_FFFF_FFFF), W'(48'h0F0F_0F0F_0F0F), W'(48'h8000_0000_0001)};
    b = {W'(48'h0000_0000_0001), W'(48'h0000_0000_0001), W'(48'hF0F0_F0F0_F0F1), W'(48'h8000_0000_0000)};
    model(a, b, 1'b0, 1'b0, er, ec);
    run_op(a, b, 1'b0, 1'b0, 2, "backpressure", er, ec);

    // Reset mid-run
    start = 1'b1; carry_init = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_a = W'(48'h1); in_b = W'(48'h2); out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_reset_state("midrun reset");
    @(posedge clk); #1;
    rst = 1'b0;
    a = {W'(0), W'(0), W'(48'h7), W'(48'hFFFF_FFFF_FFFE)};
    b = {W'(0), W'(0), W'(0), W'(48'h3)};
    model(a, b, 1'b0, 1'b0, er, ec);
    run_op(a, b, 1'b0, 1'b0, 0, "post reset", er, ec);

    // Random ops, with a bias toward all-ones words to exercise long carry chains
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < NW; k++) begin
        a[k*W +: W] = ($urandom_range(3) == 0) ? '1 : W'({$urandom, $urandom});
        b[k*W +: W] = ($urandom_range(3) == 0) ? '0 : W'({$urandom, $urandom});
      end
      cin = 1'($urandom_range(1));
      s   = 1'($urandom_range(1));
      model(a, b, cin, s, er, ec);
      run_op(a, b, cin, s, 1, $sformatf("random%0d", n), er, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
